// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL lock supervisor generating a filtered, held reset for clock_in logic
module pll_lock_supervisor #(
  parameter int LOCK_WAIT     = 16000,
  parameter int GLITCH_FILTER = 4,
  parameter int RESET_HOLD    = 8
) (
  input  logic       clock_in,
  input  logic       resetn,
  input  logic       locked,
  input  logic       sw_reset,
  input  logic       clear_cnt,
  output logic       rst_out_n,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic [1:0] status
);

  // Stable counter runs 0..LOCK_WAIT-1, hold counter 0..RESET_HOLD-1.
  // Filter counter is one bit wider than strictly needed so that the
  // incremented value can reach GLITCH_FILTER without wrapping.
  localparam int STAB_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam int FILT_W = $clog2(GLITCH_FILTER + 1);
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_WAIT - 1);
  localparam logic [FILT_W-1:0] FILT_TRIP = FILT_W'(GLITCH_FILTER);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABILIZE = 2'd1,
    ST_RUN       = 2'd2,
    ST_LOST      = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                sync_q1;
  logic                locked_s;
  logic [STAB_W-1:0]   stab_q;
  logic [STAB_W-1:0]   stab_d;
  logic [FILT_W-1:0]   filt_q;
  logic [FILT_W-1:0]   filt_d;
  logic [FILT_W-1:0]   filt_inc;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;
  logic                loss_inc;
  logic                rst_q;
  logic                ready_q;
  logic [7:0]          loss_cnt_q;

  // Two-flop synchroniser; locked_s is the only view of locked used anywhere.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= locked;
      locked_s <= sync_q1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_WAIT_LOCK;
      stab_q  <= '0;
      filt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: qualify lock, filter glitches in RUN, hold in LOST.
  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    filt_d   = filt_q;
    hold_d   = hold_q;
    loss_inc = 1'b0;
    filt_inc = filt_q + 1'b1;
    case (state_q)
      ST_WAIT_LOCK: begin
        stab_d = '0;
        filt_d = '0;
        hold_d = '0;
        if (locked_s) begin
          state_d = ST_STABILIZE;
        end
      end
      ST_STABILIZE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_RUN;
          stab_d  = '0;
          filt_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          if (filt_inc == FILT_TRIP) begin
            // Filtered loss: counted even if sw_reset arrives on the same edge.
            loss_inc = 1'b1;
            state_d  = ST_LOST;
            filt_d   = '0;
            hold_d   = '0;
          end else begin
            filt_d = filt_inc;
          end
        end else begin
          filt_d = '0;
        end
        if (sw_reset) begin
          state_d = ST_LOST;
          filt_d  = '0;
          hold_d  = '0;
        end
      end
      ST_LOST: begin
        // locked_s is deliberately ignored while the hold time runs out.
        if (hold_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase
  end

  // Reset-out and ready flops track entry to and exit from RUN with no decode after the flop.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      rst_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      rst_q   <= (state_d == ST_RUN);
      ready_q <= (state_d == ST_RUN);
    end
  end

  // Saturating lock-loss counter; clear wins over a simultaneous increment.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      loss_cnt_q <= 8'd0;
    end else if (clear_cnt) begin
      loss_cnt_q <= 8'd0;
    end else if (loss_inc && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign rst_out_n     = rst_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign status        = state_q;

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter LOCK_WAIT, default 16000, cycles locked must hold stable before reset release (100 us at 160 MHz).
REQ-002 SHALL have parameter GLITCH_FILTER, default 4, consecutive low locked cycles in RUN that count as lock loss.
REQ-003 SHALL have parameter RESET_HOLD, default 8, minimum cycles rst_out_n held low after lock loss or sw_reset.
REQ-004 SHALL have port clock_in  input  1  PLL output clock; the only clock.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port locked  input  1  PLL lock flag, asynchronous to clock_in.
REQ-007 SHALL have port sw_reset  input  1  synchronous one-cycle request to re-run the reset sequence.
REQ-008 SHALL have port clear_cnt  input  1  synchronous clear of lock_loss_cnt.
REQ-009 SHALL have port rst_out_n  output  1  active-low reset for downstream clock_in logic.
REQ-010 SHALL have port ready  output  1  high exactly when rst_out_n is high.
REQ-011 SHALL have port lock_loss_cnt  output  8  saturating count of filtered lock losses.
REQ-012 SHALL have port status  output  2  state: 0 WAIT_LOCK, 1 STABILIZE, 2 RUN, 3 LOST.

Function
REQ-013 SHALL synchronise locked through 2 flops; locked_s is the second flop output; no other logic SHALL sample locked.
REQ-014 WAIT_LOCK: on an edge with locked_s=1, SHALL go to STABILIZE with stable counter 0.
REQ-015 STABILIZE: on each edge with locked_s=1, counter SHALL increment; on the edge where counter==LOCK_WAIT-1, SHALL go to RUN.
REQ-016 STABILIZE: on any edge with locked_s=0, SHALL go to WAIT_LOCK, clear counter, leave lock_loss_cnt unchanged.
REQ-017 RUN: filter counter SHALL increment on each locked_s=0 edge and clear on each locked_s=1 edge; on the edge where it reaches GLITCH_FILTER, SHALL go to LOST and increment lock_loss_cnt.
REQ-018 RUN: sw_reset=1 SHALL go to LOST without incrementing lock_loss_cnt; sw_reset outside RUN SHALL be ignored.
REQ-019 RUN: if sw_reset and filtered loss coincide, SHALL go to LOST and increment lock_loss_cnt once.
REQ-020 LOST: SHALL stay RESET_HOLD cycles regardless of locked_s, then go to WAIT_LOCK.
REQ-021 rst_out_n and ready SHALL each be driven directly by a flop, set on the edge entering RUN and cleared on the edge leaving RUN; no combinational decode SHALL drive them.
REQ-022 lock_loss_cnt SHALL saturate at 255.
REQ-023 clear_cnt SHALL set lock_loss_cnt to 0 next edge; it SHALL take priority over a simultaneous increment.
REQ-024 Counter widths SHALL be sized from the parameters (clog2) with no wrap.

Reset
REQ-025 resetn low SHALL asynchronously force: synchroniser flops 0, state WAIT_LOCK, all counters 0, rst_out_n 0, ready 0, lock_loss_cnt 0, status 0.
REQ-026 resetn asserted mid-RUN SHALL drop rst_out_n in the same instant without waiting for a clock edge.
REQ-027 After resetn deasserts, the full WAIT_LOCK -> STABILIZE -> RUN sequence SHALL be required; no state SHALL be retained.

Verification (LOCK_WAIT=16, GLITCH_FILTER=4, RESET_HOLD=8)
REQ-028 resetn released, locked=1 throughout -> status 1 after edge 3; rst_out_n=ready=1 after edge 19; lock_loss_cnt=0.
REQ-029 In RUN, locked low 3 cycles then high -> rst_out_n stays 1, lock_loss_cnt stays 0; locked low 6 cycles -> rst_out_n 0 at the 4th low locked_s edge, lock_loss_cnt=1, status 3 for 8 cycles, then status 0; locked high again -> rst_out_n 1 after 1+16 further edges.
REQ-030 locked low 1 cycle midway through STABILIZE -> status 0, counter restarts, RUN reached 16 edges after re-entering STABILIZE, lock_loss_cnt=0.
REQ-031 sw_reset pulse in RUN -> rst_out_n 0 next edge, 8 cycles LOST, returns to RUN 8+1+16 edges later with locked high, lock_loss_cnt unchanged; sw_reset in WAIT_LOCK -> no effect.
REQ-032 Force 256 filtered losses -> lock_loss_cnt=255; clear_cnt on the same edge as a 257th loss -> lock_loss_cnt=0.
REQ-033 resetn pulsed low between edges during RUN -> rst_out_n 0 immediately, status 0, lock_loss_cnt 0.
